// File: rtl/tim_vseq.sv
`default_nettype none
// ============================================================================
//  Module   : tim_vseq
//  Brief    : Parametrised CCD vertical-clock sequencer. Runs a frame as
//             flush -> shutter -> exposure -> PD-to-VCCD transfer -> line
//             shifts, with a vact/line_done handshake towards the
//             horizontal readout. Supports normal, 2:1 binning and
//             flush-only modes.
//  Revision : 1.0  initial release
// ============================================================================
module tim_vseq #(
    parameter int LINES       = 1024,
    parameter int FLUSH_LINES = 1032,
    parameter int LCW         = 12,
    parameter int TW          = 16,
    parameter int T_VPH       = 40,
    parameter int T_XFER      = 200,
    parameter int T_SHUT      = 100
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           trigger,
    input  logic           abort,
    input  logic [1:0]     mode,
    input  logic [TW-1:0]  exp_cycles,
    input  logic           line_done,
    output logic [1:0]     v1,
    output logic           v2,
    output logic           shut,
    output logic           vact,
    output logic           busy,
    output logic           done,
    output logic [LCW-1:0] line_cnt
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] c_idle      = 4'd0;
    localparam logic [3:0] c_flush     = 4'd1;
    localparam logic [3:0] c_shut      = 4'd2;
    localparam logic [3:0] c_expose    = 4'd3;
    localparam logic [3:0] c_xfer_pre  = 4'd4;
    localparam logic [3:0] c_xfer      = 4'd5;
    localparam logic [3:0] c_xfer_post = 4'd6;
    localparam logic [3:0] c_vshift    = 4'd7;
    localparam logic [3:0] c_hwait     = 4'd8;
    localparam logic [3:0] c_fin       = 4'd9;

    // Timer reload values: the timer counts N-1 down to 0, giving N cycles.
    localparam logic [TW-1:0]  c_vph_ld    = TW'(T_VPH - 1);
    localparam logic [TW-1:0]  c_xfer_ld   = TW'(T_XFER - 1);
    localparam logic [TW-1:0]  c_shut_ld   = TW'(T_SHUT - 1);
    localparam logic [LCW-1:0] c_flush_last = LCW'(FLUSH_LINES - 1);
    localparam logic [LCW-1:0] c_lines_norm = LCW'(LINES);
    localparam logic [LCW-1:0] c_lines_bin2 = LCW'(LINES / 2);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]     state_q,    state_d;
    logic [TW-1:0]  timer_q,    timer_d;
    logic [1:0]     step_q,     step_d;
    logic [LCW-1:0] shift_q,    shift_d;
    logic [LCW-1:0] line_cnt_q, line_cnt_d;
    logic [1:0]     mode_q,     mode_d;
    logic [TW-1:0]  exp_q,      exp_d;

    logic [1:0]     v1_q,   v1_d;
    logic           v2_q,   v2_d;
    logic           shut_q, shut_d;
    logic           vact_q, vact_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // ------------------------------------------------------------------
    // Decoded helpers
    // ------------------------------------------------------------------
    logic           w_bin2;
    logic           w_flush_only;
    logic           w_step_end;
    logic           w_line_end;
    logic [LCW-1:0] w_line_inc;
    logic [LCW-1:0] w_line_target;
    logic [LCW-1:0] w_vshift_last;

    assign w_bin2        = (mode_q == 2'b01);
    assign w_flush_only  = (mode_q == 2'b10);
    assign w_step_end    = (timer_q == '0);
    // A line shift ends when the last of its three phase steps expires.
    assign w_line_end    = w_step_end && (step_q >= 2'd2);
    assign w_line_inc    = line_cnt_q + LCW'(1);
    assign w_line_target = w_bin2 ? c_lines_bin2 : c_lines_norm;
    // Bin2 merges two line shifts into one readout line.
    assign w_vshift_last = w_bin2 ? LCW'(1) : LCW'(0);

    // Sequencer state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_idle;
            timer_q    <= '0;
            step_q     <= '0;
            shift_q    <= '0;
            line_cnt_q <= '0;
            mode_q     <= '0;
            exp_q      <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            step_q     <= step_d;
            shift_q    <= shift_d;
            line_cnt_q <= line_cnt_d;
            mode_q     <= mode_d;
            exp_q      <= exp_d;
        end
    end

    // Next-state and counter logic; abort overrides every normal transition
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        step_d     = step_q;
        shift_d    = shift_q;
        line_cnt_d = line_cnt_q;
        mode_d     = mode_q;
        exp_d      = exp_q;

        if (abort && (state_q != c_idle)) begin
            state_d    = c_idle;
            timer_d    = '0;
            step_d     = '0;
            shift_d    = '0;
            line_cnt_d = '0;
        end else begin
            case (state_q)
                c_idle: begin
                    if (trigger) begin
                        state_d    = c_flush;
                        mode_d     = mode;
                        exp_d      = exp_cycles;
                        line_cnt_d = '0;
                        timer_d    = c_vph_ld;
                        step_d     = '0;
                        shift_d    = '0;
                    end
                end

                c_flush: begin
                    if (!w_step_end) begin
                        timer_d = timer_q - TW'(1);
                    end else if (!w_line_end) begin
                        step_d  = step_q + 2'd1;
                        timer_d = c_vph_ld;
                    end else if (shift_q != c_flush_last) begin
                        shift_d = shift_q + LCW'(1);
                        step_d  = '0;
                        timer_d = c_vph_ld;
                    end else begin
                        shift_d = '0;
                        step_d  = '0;
                        if (w_flush_only) begin
                            state_d = c_fin;
                            timer_d = '0;
                        end else begin
                            state_d = c_shut;
                            timer_d = c_shut_ld;
                        end
                    end
                end

                c_shut: begin
                    if (!w_step_end) begin
                        timer_d = timer_q - TW'(1);
                    end else if (exp_q == '0) begin
                        // Zero exposure skips EXPOSE entirely.
                        state_d = c_xfer_pre;
                        timer_d = c_vph_ld;
                    end else begin
                        state_d = c_expose;
                        timer_d = exp_q - TW'(1);
                    end
                end

                c_expose: begin
                    if (!w_step_end) begin
                        timer_d = timer_q - TW'(1);
                    end else begin
                        state_d = c_xfer_pre;
                        timer_d = c_vph_ld;
                    end
                end

                c_xfer_pre: begin
                    if (!w_step_end) begin
                        timer_d = timer_q - TW'(1);
                    end else begin
                        state_d = c_xfer;
                        timer_d = c_xfer_ld;
                    end
                end

                c_xfer: begin
                    if (!w_step_end) begin
                        timer_d = timer_q - TW'(1);
                    end else begin
                        state_d = c_xfer_post;
                        timer_d = c_vph_ld;
                    end
                end

                c_xfer_post: begin
                    if (!w_step_end) begin
                        timer_d = timer_q - TW'(1);
                    end else begin
                        state_d = c_vshift;
                        timer_d = c_vph_ld;
                        step_d  = '0;
                        shift_d = '0;
                    end
                end

                c_vshift: begin
                    if (!w_step_end) begin
                        timer_d = timer_q - TW'(1);
                    end else if (!w_line_end) begin
                        step_d  = step_q + 2'd1;
                        timer_d = c_vph_ld;
                    end else if (shift_q != w_vshift_last) begin
                        shift_d = shift_q + LCW'(1);
                        step_d  = '0;
                        timer_d = c_vph_ld;
                    end else begin
                        state_d = c_hwait;
                        shift_d = '0;
                        step_d  = '0;
                        timer_d = '0;
                    end
                end

                c_hwait: begin
                    if (line_done) begin
                        line_cnt_d = w_line_inc;
                        if (w_line_inc == w_line_target) begin
                            state_d = c_fin;
                        end else begin
                            // Next shift starts in the same cycle vact drops.
                            state_d = c_vshift;
                            timer_d = c_vph_ld;
                            step_d  = '0;
                            shift_d = '0;
                        end
                    end
                end

                c_fin: begin
                    state_d = c_idle;
                end

                default: begin
                    state_d = c_idle;
                    timer_d = '0;
                    step_d  = '0;
                    shift_d = '0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so every output is registered
    always_comb begin
        v1_d   = 2'b00;
        v2_d   = 1'b1;
        shut_d = 1'b0;
        vact_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;

        case (state_d)
            c_flush, c_vshift: begin
                busy_d = 1'b1;
                case (step_d)
                    2'd0:    begin v1_d = 2'b01; v2_d = 1'b1; end
                    2'd1:    begin v1_d = 2'b01; v2_d = 1'b0; end
                    default: begin v1_d = 2'b00; v2_d = 1'b0; end
                endcase
            end
            c_shut: begin
                busy_d = 1'b1;
                shut_d = 1'b1;
            end
            c_expose: begin
                busy_d = 1'b1;
            end
            c_xfer_pre, c_xfer_post: begin
                busy_d = 1'b1;
                v1_d   = 2'b01;
            end
            c_xfer: begin
                busy_d = 1'b1;
                v1_d   = 2'b10;
            end
            c_hwait: begin
                busy_d = 1'b1;
                vact_d = 1'b1;
            end
            c_fin: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 2'b00;
            v2_q   <= 1'b1;
            shut_q <= 1'b0;
            vact_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            shut_q <= shut_d;
            vact_q <= vact_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign v1       = v1_q;
    assign v2       = v2_q;
    assign shut     = shut_q;
    assign vact     = vact_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign line_cnt = line_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tim_vseq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tim_vseq
//  Brief    : Self-checking bench for tim_vseq. Output activity is run-length
//             encoded into segments and compared against a queue of expected
//             segments pushed before each frame is triggered.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tim_vseq;

    localparam int LINES       = 4;
    localparam int FLUSH_LINES = 2;
    localparam int LCW         = 12;
    localparam int TW          = 16;
    localparam int T_VPH       = 2;
    localparam int T_XFER      = 5;
    localparam int T_SHUT      = 3;
    localparam int HS_WAIT     = 3;

    // Output vector {v1[1:0], v2, shut, vact, busy, done}
    localparam logic [6:0] C_IDLE = 7'b00_1_0_0_0_0;
    localparam logic [6:0] C_F0   = 7'b01_1_0_0_1_0;
    localparam logic [6:0] C_F1   = 7'b01_0_0_0_1_0;
    localparam logic [6:0] C_F2   = 7'b00_0_0_0_1_0;
    localparam logic [6:0] C_SH   = 7'b00_1_1_0_1_0;
    localparam logic [6:0] C_EX   = 7'b00_1_0_0_1_0;
    localparam logic [6:0] C_XF   = 7'b10_1_0_0_1_0;
    localparam logic [6:0] C_HW   = 7'b00_1_0_1_1_0;
    localparam logic [6:0] C_FN   = 7'b00_1_0_0_1_1;

    logic           clk;
    logic           rst;
    logic           trigger;
    logic           abort;
    logic [1:0]     mode;
    logic [TW-1:0]  exp_cycles;
    logic           line_done;
    logic [1:0]     v1;
    logic           v2;
    logic           shut;
    logic           vact;
    logic           busy;
    logic           done;
    logic [LCW-1:0] line_cnt;

    typedef struct {
        logic [6:0] vec;
        int         len;
    } seg_t;

    seg_t sb[$];
    int   n_vec;
    int   n_err;
    logic spur_req;

    tim_vseq #(
        .LINES       (LINES),
        .FLUSH_LINES (FLUSH_LINES),
        .LCW         (LCW),
        .TW          (TW),
        .T_VPH       (T_VPH),
        .T_XFER      (T_XFER),
        .T_SHUT      (T_SHUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .abort      (abort),
        .mode       (mode),
        .exp_cycles (exp_cycles),
        .line_done  (line_done),
        .v1         (v1),
        .v2         (v2),
        .shut       (shut),
        .vact       (vact),
        .busy       (busy),
        .done       (done),
        .line_cnt   (line_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected-segment builder; adjacent equal vectors merge into one run.
    task automatic add_seg(inout seg_t fq[$], input logic [6:0] vec, input int len);
        seg_t s;
        if (fq.size() > 0 && fq[$].vec === vec) begin
            fq[$].len = fq[$].len + len;
        end else begin
            s.vec = vec;
            s.len = len;
            fq.push_back(s);
        end
    endtask

    task automatic add_line(inout seg_t fq[$]);
        add_seg(fq, C_F0, T_VPH);
        add_seg(fq, C_F1, T_VPH);
        add_seg(fq, C_F2, T_VPH);
    endtask

    // keep>0 truncates the frame to its first keep segments, the last of
    // which is cut short to last_len cycles (abort / reset mid-frame).
    task automatic build_frame(input logic [1:0] m, input int e, input int keep, input int last_len);
        seg_t fq[$];
        int   nl;
        int   spl;
        for (int i = 0; i < FLUSH_LINES; i++) add_line(fq);
        if (m == 2'b10) begin
            add_seg(fq, C_FN, 1);
        end else begin
            add_seg(fq, C_SH, T_SHUT);
            if (e > 0) add_seg(fq, C_EX, e);
            add_seg(fq, C_F0, T_VPH);
            add_seg(fq, C_XF, T_XFER);
            add_seg(fq, C_F0, T_VPH);
            nl  = (m == 2'b01) ? LINES / 2 : LINES;
            spl = (m == 2'b01) ? 2 : 1;
            for (int l = 0; l < nl; l++) begin
                for (int s = 0; s < spl; s++) add_line(fq);
                add_seg(fq, C_HW, HS_WAIT);
            end
            add_seg(fq, C_FN, 1);
        end
        if (keep > 0) begin
            while (fq.size() > keep) void'(fq.pop_back());
            fq[keep-1].len = last_len;
        end
        foreach (fq[i]) sb.push_back(fq[i]);
    endtask

    task automatic close_seg(input logic [6:0] vec, input int len);
        seg_t e;
        n_vec++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL sb_underrun: observed seg %b x%0d expected none", vec, len);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            assert (vec === e.vec && len === e.len) else begin
                n_err++;
                $error("FAIL segment: observed %b x%0d expected %b x%0d", vec, len, e.vec, e.len);
            end
        end
    endtask

    // Run-length monitor of the output vector
    initial begin : monitor
        logic [6:0] prev;
        logic [6:0] cur;
        int         len;
        prev = C_IDLE;
        len  = 0;
        forever begin
            @(negedge clk);
            cur = {v1, v2, shut, vact, busy, done};
            if (cur !== prev) begin
                if (prev !== C_IDLE) close_seg(prev, len);
                prev = cur;
                len  = 1;
            end else begin
                len++;
            end
        end
    end

    // Horizontal-side responder: line_done sampled on the 3rd edge after vact rises
    initial begin : responder
        int hw;
        line_done = 1'b0;
        hw        = 0;
        forever begin
            @(negedge clk);
            line_done = 1'b0;
            if (spur_req) begin
                line_done = 1'b1;
                spur_req  = 1'b0;
            end else if (vact === 1'b1) begin
                hw++;
                if (hw == HS_WAIT) begin
                    line_done = 1'b1;
                    hw        = 0;
                end
            end else begin
                hw = 0;
            end
        end
    end

    task automatic wait_cond(input int which, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (which)
                0: hit = (done === 1'b1);
                1: hit = (shut === 1'b1);
                2: hit = (v1 === 2'b10);
                3: hit = (v2 === 1'b0 && busy === 1'b1);
                default: hit = (line_cnt === LCW'(1) && vact === 1'b1);
            endcase
            if (hit) break;
        end
        n_vec++;
        assert (hit) else begin
            n_err++;
            $error("FAIL %s: observed timeout after %0d cycles expected event", tag, budget);
        end
    endtask

    task automatic start(input logic [1:0] m, input logic [TW-1:0] e);
        mode       = m;
        exp_cycles = e;
        trigger    = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_v1", 32'(v1), 32'h1);
    endtask

    initial begin : stimulus
        n_vec      = 0;
        n_err      = 0;
        spur_req   = 1'b0;
        rst        = 1'b1;
        trigger    = 1'b0;
        abort      = 1'b0;
        mode       = 2'b00;
        exp_cycles = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_v1", 32'(v1), 32'h0);
        chk("rst_v2", 32'(v2), 32'h1);
        chk("rst_shut", 32'(shut), 32'h0);
        chk("rst_vact", 32'(vact), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_line_cnt", 32'(line_cnt), 32'h0);

        // Reset together with trigger: frame must not start
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        rst     = 1'b0;
        chk("rst_trig_busy", 32'(busy), 32'h0);
        chk("rst_trig_v1", 32'(v1), 32'h0);
        @(negedge clk);
        chk("rst_trig_idle", 32'(busy), 32'h0);

        // Normal frame with a trigger while busy and a spurious line_done
        build_frame(2'b00, 10, 0, 0);
        start(2'b00, 16'd10);
        wait_cond(1, 200, "shut_seen");
        trigger    = 1'b1;
        mode       = 2'b10;
        exp_cycles = 16'd3;
        @(negedge clk);
        trigger = 1'b0;
        wait_cond(2, 200, "xfer_seen");
        wait_cond(3, 200, "vshift_seen");
        spur_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("spur_line_cnt", 32'(line_cnt), 32'h0);
        wait_cond(0, 500, "done_normal");
        @(negedge clk);
        chk("normal_busy_after", 32'(busy), 32'h0);
        chk("normal_line_cnt", 32'(line_cnt), 32'd4);
        repeat (3) @(negedge clk);
        chk("idle_line_cnt_hold", 32'(line_cnt), 32'd4);

        // Bin2
        build_frame(2'b01, 5, 0, 0);
        start(2'b01, 16'd5);
        wait_cond(0, 500, "done_bin2");
        @(negedge clk);
        chk("bin2_line_cnt", 32'(line_cnt), 32'd2);

        // Flush-only
        build_frame(2'b10, 7, 0, 0);
        start(2'b10, 16'd7);
        wait_cond(0, 500, "done_flush");
        @(negedge clk);
        chk("flush_line_cnt", 32'(line_cnt), 32'd0);
        chk("flush_busy_after", 32'(busy), 32'h0);

        // Zero exposure
        build_frame(2'b00, 0, 0, 0);
        start(2'b00, 16'd0);
        wait_cond(0, 500, "done_exp0");
        @(negedge clk);
        chk("exp0_line_cnt", 32'(line_cnt), 32'd4);

        // Abort during HWAIT of line 2
        build_frame(2'b00, 10, 18, 1);
        start(2'b00, 16'd10);
        wait_cond(4, 500, "hwait2_seen");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_v1", 32'(v1), 32'h0);
        chk("abort_v2", 32'(v2), 32'h1);
        chk("abort_vact", 32'(vact), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_line_cnt", 32'(line_cnt), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        repeat (3) @(negedge clk);

        // Full frame after abort
        build_frame(2'b00, 4, 0, 0);
        start(2'b00, 16'd4);
        wait_cond(0, 500, "done_after_abort");
        @(negedge clk);
        chk("post_abort_line_cnt", 32'(line_cnt), 32'd4);

        // Reset mid-XFER
        build_frame(2'b00, 10, 10, 3);
        start(2'b00, 16'd10);
        wait_cond(2, 200, "xfer_seen_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstx_v1", 32'(v1), 32'h0);
        chk("rstx_v2", 32'(v2), 32'h1);
        chk("rstx_shut", 32'(shut), 32'h0);
        chk("rstx_vact", 32'(vact), 32'h0);
        chk("rstx_busy", 32'(busy), 32'h0);
        chk("rstx_done", 32'(done), 32'h0);
        chk("rstx_line_cnt", 32'(line_cnt), 32'h0);
        rst = 1'b0;

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tim_vseq.md
# tim_vseq

Parametrised CCD vertical-clock sequencer for the timing generator. It replaces the fixed vertical FSM with a configurable frame sequence:
- flush
- electronic-shutter pulse
- timed exposure
- photodiode-to-VCCD transfer
- line-by-line vertical shifting

The horizontal side reads each line over a `vact`/`line_done` handshake. It supports normal, 2:1 vertical binning and flush-only modes, and sits between the trigger logic and the CCD vertical drivers (`ccd_v1`, `ccd_v2`, `ccd_shut`).

## Interface
- `LINES`, 1024: lines shifted out in normal mode. Must be even.
- `FLUSH_LINES`, 1032: line shifts performed in the FLUSH state.
- `LCW`, 12: width of line counters. Must satisfy 2^LCW > max(`LINES`, `FLUSH_LINES`).
- `TW`, 16: width of the timer and of `exp_cycles`.
- `T_VPH`, 40: cycles per vertical phase step. Must be ≥1.
- `T_XFER`, 200: cycles `v1` is held at high level during transfer. Must be ≥1.
- `T_SHUT`, 100: cycles of the shutter pulse. Must be ≥1.
- `clk` in 1: pixel clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `trigger` in 1: start frame. Sampled only in IDLE.
- `abort` in 1: synchronous cancel of the current frame.
- `mode` in 2: 00 normal; 01 bin2; 10 flush-only; 11 treated as normal. Latched with `trigger`.
- `exp_cycles` in TW: exposure length in cycles. Latched with `trigger`.
- `line_done` in 1: one-cycle pulse from the horizontal FSM meaning the line has been read.
- `v1` out 2: V1 level. 00 low, 01 mid, 10 high.
- `v2` out 1: V2 level.
- `shut` out 1: electronic-shutter pulse, active high.
- `vact` out 1: a line is in the HCCD and ready for readout.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse when a frame completes.
- `line_cnt` out LCW: number of lines read out in the current frame.

## Operation
- **States:** IDLE, FLUSH, SHUT, EXPOSE, XFER_PRE, XFER, XFER_POST, VSHIFT, HWAIT, FIN.
- **Output levels by state:**
  - Idle level (IDLE, SHUT, EXPOSE, HWAIT, FIN): `v1`=00, `v2`=1.
  - XFER_PRE and XFER_POST: `v1`=01, `v2`=1, each for `T_VPH` cycles.
  - XFER: `v1`=10, `v2`=1, for `T_XFER` cycles.
- **Line shift:** three steps of `T_VPH` cycles each:
  - (`v1`=01, `v2`=1)
  - (`v1`=01, `v2`=0)
  - (`v1`=00, `v2`=0)
  - A line shift therefore lasts 3·`T_VPH` cycles. It is used by both FLUSH and VSHIFT.
- **IDLE → FLUSH** on `trigger`. `mode` and `exp_cycles` are latched at the same time.
- **FLUSH:** `FLUSH_LINES` line shifts with no handshake. Then:
  - flush-only mode → FIN.
  - otherwise → SHUT.
- **SHUT:** `shut`=1 for `T_SHUT` cycles → EXPOSE.
- **EXPOSE:** holds for `exp_cycles` cycles → XFER_PRE. If `exp_cycles`=0, EXPOSE is skipped and SHUT goes directly to XFER_PRE.
- **Transfer:** XFER_PRE → XFER → XFER_POST → VSHIFT.
- **VSHIFT:**
  - normal mode: 1 line shift.
  - bin2 mode: 2 line shifts back-to-back.
  - Then → HWAIT.
- **HWAIT:** `vact`=1 until `line_done` is sampled.
  - On `line_done`, `vact` drops and `line_cnt` increments.
  - If lines read = `LINES` (normal) or `LINES`/2 (bin2) → FIN; otherwise → VSHIFT.
- **FIN:** `done`=1 for one cycle → IDLE. `busy`=0 from IDLE onward.
- **Ignored inputs:**
  - `trigger` while `busy`.
  - `line_done` outside HWAIT.
- **`abort` (any non-IDLE state):** next edge → IDLE with all outputs at reset values. `done` is not pulsed.
- **Priority:** `rst` > `abort` > normal transitions. If `abort` and `line_done` occur in the same cycle, abort wins and `line_cnt` is cleared.
- **Counters:** the timer counts `T_*−1` down to 0; the phase-step counter is 2 bits. `line_cnt` is cleared on `trigger` and holds its final value in IDLE until the next `trigger`. No wrap is possible given the `LCW` constraint.

## Timing
- **Reset values:** state IDLE, `v1`=00, `v2`=1, `shut`=0, `vact`=0, `busy`=0, `done`=0, `line_cnt`=0, timers 0.
- **All outputs are registered.**
- **Start latency:** with `trigger` sampled at edge k, `busy`=1 and the first FLUSH step (`v1`=01) are visible after edge k.
- **Handshake:** `line_done` high at edge m while in HWAIT gives `vact`=0 after edge m, and the next VSHIFT begins in the same cycle.
- **Frame length in normal mode:** `FLUSH_LINES`·3·`T_VPH` + `T_SHUT` + `exp_cycles` + 2·`T_VPH` + `T_XFER` + `LINES`·3·`T_VPH` + handshake wait + 1 (FIN).
- **Simultaneous `rst` and `trigger`:** reset wins, and the frame does not start.

## Test plan
Parameters for all scenarios: `LINES`=4, `FLUSH_LINES`=2, `T_VPH`=2, `T_XFER`=5, `T_SHUT`=3.
- **Normal frame:** `trigger` with `exp_cycles`=10, `line_done` 3 cycles after each `vact` rise → 12 flush cycles, `shut` high 3 cycles, 10 exposure cycles, `v1`=10 for exactly 5 cycles, 4 `vact` pulses, `line_cnt`=4, one `done` pulse, `busy` low afterwards.
- **Bin2:** `mode`=01 → 12 shift cycles between transfer and each `vact`, exactly 2 `vact` pulses, `line_cnt`=2.
- **Flush-only:** `mode`=10 → `shut` never asserts, `v1` never 10, `vact` never asserts, `done` after 12 flush cycles + 1.
- **Edge cases:** `exp_cycles`=0 → XFER_PRE starts the cycle after `shut` falls. `trigger` pulsed while `busy` → no effect on the sequence. Spurious `line_done` during VSHIFT → `line_cnt` unchanged.
- **`abort` during HWAIT of line 2** → next cycle `v1`=00, `v2`=1, `vact`=0, `busy`=0, `line_cnt`=0, no `done`. A new `trigger` then runs a full frame correctly.
- **`rst` mid-XFER** → all outputs at reset values after the next edge. `rst` together with `trigger` → stays IDLE.
